// File: rtl/la_uart_pkg.sv
// Shared types and LA bit positions for the LA-fed UART transmitter.
// The FSM state list includes PARITY, which is only used when LA_UART_PARITY_EN is defined.
package la_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int LA_DATA_LSB  = 0;
    localparam int LA_WR_BIT    = 8;
    localparam int LA_FLUSH_BIT = 9;
    localparam int STAT_BUSY    = 5;
    localparam int STAT_OVF     = 6;
    localparam int STAT_FULL    = 7;

endpackage

// File: rtl/la_uart_fifo.sv
// Small synchronous byte FIFO with show-ahead read, so the transmitter can pop and load in one edge.
// Flush clears both pointers and the level and overrides any push or pop in the same cycle.
module la_uart_fifo
    import la_uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (level_reg == '0);
    assign full  = (level_reg == LVL_W'(DEPTH));

    // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/la_uart_tx.sv
// LA-fed UART transmitter: toggle-detected byte writes into a FIFO, serialized 8N1 on uart_tx.
// Define LA_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module la_uart_tx
    import la_uart_pkg::*;
#(
    parameter int CLK_DIV    = 4167,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [31:0] la_data_in,
    input  logic [31:0] la_oenb,
    output logic [31:0] la_data_out,
    output logic        uart_tx,
    output logic        uart_oeb
);

    localparam int          LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    logic             prev_wr_reg;
    logic             push_req;
    logic             flush_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [LVL_W-1:0] fifo_level;
    logic             ovf_reg;
    logic             busy;
    logic             load;
    logic             bit_done;

    tx_state_t   state_reg,   state_next;
    logic [15:0] baud_reg,    baud_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg,   shift_next;
    logic        tx_reg,      tx_next;
`ifdef LA_UART_PARITY_EN
    logic        par_reg,     par_next;
`endif

    logic unused_la;
    assign unused_la = ^{la_data_in[31:10], la_oenb[31:10], la_oenb[7:0]};

    assign push_req  = !la_oenb[LA_WR_BIT] && (la_data_in[LA_WR_BIT] != prev_wr_reg);
    assign flush_req = !la_oenb[LA_FLUSH_BIT] && la_data_in[LA_FLUSH_BIT];
    assign fifo_push = push_req && !flush_req;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            prev_wr_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            prev_wr_reg <= la_data_in[LA_WR_BIT];
            if (flush_req)
                ovf_reg <= 1'b0;
            else if (fifo_push && fifo_full && !fifo_pop)
                ovf_reg <= 1'b1;
        end
    end

    la_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock  (clock),
        .resetb (resetb),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .flush  (flush_req),
        .wdata  (la_data_in[LA_DATA_LSB +: 8]),
        .rdata  (fifo_rdata),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
`ifdef LA_UART_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
`ifdef LA_UART_PARITY_EN
            par_reg     <= par_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
`ifdef LA_UART_PARITY_EN
        par_next     = par_reg;
`endif
        fifo_pop     = 1'b0;
        load         = 1'b0;
        bit_done     = (baud_reg == 16'd0);

        // Every non-idle state times one bit period the same way.
        if (state_reg != IDLE)
            baud_next = bit_done ? BAUD_RELOAD : baud_reg - 16'd1;

        case (state_reg)
            IDLE: load = !fifo_empty;
            START: if (bit_done) begin
                state_next   = DATA;
                bit_idx_next = 3'd0;
                tx_next      = shift_reg[0];
            end
            DATA: if (bit_done) begin
                if (bit_idx_reg == 3'd7) begin
`ifdef LA_UART_PARITY_EN
                    state_next = PARITY;
                    tx_next    = par_reg;
`else
                    state_next = STOP;
                    tx_next    = 1'b1;
`endif
                end else begin
                    bit_idx_next = bit_idx_reg + 3'd1;
                    shift_next   = shift_reg >> 1;
                    tx_next      = shift_reg[1];
                end
            end
`ifdef LA_UART_PARITY_EN
            PARITY: if (bit_done) begin
                state_next = STOP;
                tx_next    = 1'b1;
            end
`endif
            STOP: if (bit_done) begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_next = IDLE;
                    baud_next  = 16'd0;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Chained from STOP as well as IDLE, so queued frames follow with no idle gap.
        if (load) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_rdata;
            baud_next  = BAUD_RELOAD;
            state_next = START;
            tx_next    = 1'b0;
`ifdef LA_UART_PARITY_EN
            par_next   = ^fifo_rdata;
`endif
        end

        if (flush_req) begin
            fifo_pop     = 1'b0;
            state_next   = IDLE;
            baud_next    = 16'd0;
            bit_idx_next = 3'd0;
            tx_next      = 1'b1;
        end
    end

    assign busy = (state_reg != IDLE) || !fifo_empty;

    always_comb begin
        la_data_out            = '0;
        la_data_out[4:0]       = 5'(fifo_level);
        la_data_out[STAT_BUSY] = busy;
        la_data_out[STAT_OVF]  = ovf_reg;
        la_data_out[STAT_FULL] = fifo_full;
    end

    assign uart_tx  = tx_reg;
    assign uart_oeb = 1'b0;

endmodule

// File: tb/tb_la_uart_tx.sv
// Directed bench for la_uart_tx at CLK_DIV=4: reset, single frame, overflow, oenb gating, flush, mid-frame reset.
// Frame expectations follow LA_UART_PARITY_EN when the bench is built with it.
module tb_la_uart_tx;

    localparam int DIV = 4;
`ifdef LA_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic        clock = 1'b0;
    logic        resetb = 1'b1;
    logic [31:0] la_data_in = '0;
    logic [31:0] la_oenb = '0;
    logic [31:0] la_data_out;
    logic        uart_tx;
    logic        uart_oeb;

    int n_checks = 0;
    int n_errors = 0;
    int tx_edges = 0;
    int edges_snap;

    la_uart_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (8)
    ) dut (
        .clock       (clock),
        .resetb      (resetb),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .uart_tx     (uart_tx),
        .uart_oeb    (uart_oeb)
    );

    always #5 clock = ~clock;

    always @(uart_tx) tx_edges++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic toggle(input logic [7:0] b);
        la_data_in[7:0] = b;
        la_data_in[8]   = ~la_data_in[8];
    endtask

    // Expected line level s cycles after the start bit first appears.
    function automatic logic exp_bit(input logic [7:0] b, input int s);
        int k = s / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef LA_UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_frame(input logic [7:0] b, input int first);
        for (int s = first; s < FRAME; s++) begin
            check($sformatf("frame_%02h_s%0d", b, s), {31'b0, uart_tx}, {31'b0, exp_bit(b, s)});
            tick();
        end
        $display("frame byte=%02h checked from sample %0d", b, first);
    endtask

    initial begin
        // Reset and quiet idle line
        #3 resetb = 1'b0;
        #1;
        check("rst_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_status", la_data_out, 32'h0);
        check("rst_oeb", {31'b0, uart_oeb}, 32'h0);
        tick();
        tick();
        resetb = 1'b1;
        edges_snap = tx_edges;
        for (int i = 0; i < 1000; i++) tick();
        check("idle_edges", tx_edges, edges_snap);
        check("idle_tx", {31'b0, uart_tx}, 32'h1);
        check("idle_status", la_data_out, 32'h0);
        $display("reset/idle: 1000 quiet cycles");

        // Single byte 0x41: level 1 after the sampling edge, start bit one edge later
        toggle(8'h41);
        tick();
        check("wr41_status", la_data_out, 32'h21);
        tick();
        check("wr41_busy", la_data_out, 32'h20);
        check_frame(8'h41, 0);
        check("wr41_done_status", la_data_out, 32'h0);
        check("wr41_done_tx", {31'b0, uart_tx}, 32'h1);

        // Overflow: 0xA5 occupies the shifter so nine queued toggles overflow the 8-deep FIFO
        toggle(8'hA5);
        tick();
        tick();
        check("ovf_a5_s0", {31'b0, uart_tx}, {31'b0, exp_bit(8'hA5, 0)});
        for (int i = 0; i < 9; i++) begin
            toggle(8'(i));
            tick();
            check($sformatf("ovf_a5_s%0d", i + 1), {31'b0, uart_tx}, {31'b0, exp_bit(8'hA5, i + 1)});
        end
        check("ovf_status_full", la_data_out, 32'hE8);
        tick();
        check_frame(8'hA5, 10);
        for (int b = 0; b < 8; b++) check_frame(8'(b), 0);
        check("ovf_done_status", la_data_out, 32'h40);
        edges_snap = tx_edges;
        for (int i = 0; i < 2 * FRAME; i++) tick();
        check("ovf_no_byte08", tx_edges, edges_snap);

        // Writes with la_oenb[8] high are invisible
        la_oenb[8] = 1'b1;
        edges_snap = tx_edges;
        for (int i = 0; i < 5; i++) begin
            toggle(8'hC3);
            tick();
            tick();
        end
        check("oenb_status", la_data_out, 32'h40);
        la_oenb[8] = 1'b0;
        tick();
        tick();
        check("oenb_restore_status", la_data_out, 32'h40);
        check("oenb_edges", tx_edges, edges_snap);
        $display("oenb gating: 5 masked toggles");

        // Flush mid-DATA of 0x55 with three bytes queued
        toggle(8'h55);
        tick();
        check("fl_status_1", la_data_out, 32'h61);
        tick();
        toggle(8'h11); tick();
        toggle(8'h22); tick();
        toggle(8'h33); tick();
        check("fl_status_q3", la_data_out, 32'h63);
        for (int i = 0; i < 7; i++) tick();
        check("fl_pre_tx", {31'b0, uart_tx}, {31'b0, exp_bit(8'h55, 10)});
        la_data_in[9] = 1'b1;
        toggle(8'h99);
        tick();
        check("fl_tx", {31'b0, uart_tx}, 32'h1);
        check("fl_status", la_data_out, 32'h0);
        toggle(8'h9A);
        tick();
        check("fl_push_ignored", la_data_out, 32'h0);
        la_data_in[9] = 1'b0;
        tick();
        check("fl_release_status", la_data_out, 32'h0);
        edges_snap = tx_edges;
        for (int i = 0; i < 100; i++) tick();
        check("fl_no_frames", tx_edges, edges_snap);
        check("fl_idle_tx", {31'b0, uart_tx}, 32'h1);
        $display("flush: frame aborted, queue dropped");

        // Even-parity byte (plain 8N1 frame when parity is not built in)
        toggle(8'h07);
        tick();
        tick();
        check_frame(8'h07, 0);
        check("b07_done_status", la_data_out, 32'h0);

        // Asynchronous reset during a start bit
        toggle(8'h3C);
        tick();
        tick();
        check("arst_pre_tx", {31'b0, uart_tx}, 32'h0);
        #2 resetb = 1'b0;
        #1;
        check("arst_tx", {31'b0, uart_tx}, 32'h1);
        check("arst_status", la_data_out, 32'h0);
        tick();
        resetb = 1'b1;
        edges_snap = tx_edges;
        for (int i = 0; i < 60; i++) tick();
        check("arst_quiet", tx_edges, edges_snap);
        check("arst_final_status", la_data_out, 32'h0);
        $display("async reset: partial frame discarded");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/la_uart_tx.md
# la_uart_tx

Logic-analyzer-fed UART transmitter in the user project area. Firmware on the management SoC writes bytes through LA probes. The block buffers them in a small FIFO and serializes them 8N1 onto mprj_io[6], where the testbench UART monitor decodes them. It also reports FIFO and transmitter status back to firmware through la_data_out.

## Interface
- CLK_DIV, 4167 — clock cycles per UART bit (40 MHz / 9600). Legal range 2..65535; the baud counter is 16 bits.
- FIFO_DEPTH, 8 — byte FIFO depth. Must be a power of 2, range 2..16.
- clock  in  1  — single system clock (the caravel core clock). LA inputs are in the same domain; no synchronizers.
- resetb  in  1  — asynchronous, active-low reset.
- la_data_in  in  32  — LA probes:
  - [7:0] data byte.
  - [8] write toggle.
  - [9] flush, level-sensitive.
  - Other bits ignored.
- la_oenb  in  32  — LA output-enable bars. A probe bit counts only while its oenb bit is 0.
- la_data_out  out  32  — status, all other bits 0:
  - [4:0] FIFO level, zero-extended.
  - [5] busy.
  - [6] overflow, sticky.
  - [7] full.
- uart_tx  out  1  — serial output, idle high, registered.
- uart_oeb  out  1  — pad output-enable bar, constant 0.

## Operation
- **Write detect**
  - A register prev_wr samples la_data_in[8] every cycle; it resets to 0.
  - A push is requested when la_oenb[8]==0 and la_data_in[8]!=prev_wr.
  - One push per toggle edge; the byte pushed is la_data_in[7:0] in the same cycle.
- **FIFO**
  - Synchronous, first-in first-out.
  - Level ranges 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- **Full**
  - A push while full is dropped and overflow is set.
  - Exception: if a pop happens in the same cycle, the push is accepted and the level is unchanged.
- **Empty**
  - A pop only occurs when level>0.
  - A push and a pop in the same cycle while empty cannot happen: the pop needs level>0 in the prior state.
- **Flush** (la_data_in[9]==1 and la_oenb[9]==0)
  - Every cycle it is asserted: level←0, overflow←0.
  - The FSM returns to IDLE and uart_tx←1 on the next edge, aborting any frame in progress.
  - Pushes are ignored while flush is asserted.
  - Flush has priority over all other events.
- **Transmitter FSM**: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: if level>0, pop the byte into the shift register, load baud_cnt←CLK_DIV-1, go to START with uart_tx←0.
  - START, DATA, PARITY, STOP: each bit lasts exactly CLK_DIV cycles. The state advances when baud_cnt==0, and baud_cnt reloads CLK_DIV-1.
  - DATA: 8 bits, LSB first, counted by a 3-bit bit_idx.
  - STOP: uart_tx=1 for CLK_DIV cycles. On expiry, if level>0 the FSM goes directly to START (pop in the same cycle), so back-to-back frames have no idle gap.
- **Status**
  - busy = (state!=IDLE) | (level!=0).
  - full = (level==FIFO_DEPTH).

## Timing
- Reset values: uart_tx=1, uart_oeb=0, la_data_out=0, state=IDLE, level=0, overflow=0, prev_wr=0, baud_cnt=0, bit_idx=0.
- Idle, empty FIFO, toggle sampled at edge N:
  - level=1 after edge N.
  - Pop and uart_tx=0 after edge N+1; latency is 2 cycles.
- Frame length: 10·CLK_DIV cycles, or 11·CLK_DIV with parity.
- la_data_out reflects registered state. Level updates one cycle after the push or pop edge.
- Reset asserted mid-frame: all state clears asynchronously and uart_tx goes high immediately. The partial frame is lost.

## Configuration
- LA_UART_PARITY_EN defined: a PARITY state is inserted between DATA and STOP.
  - Even parity: the parity bit is the XOR of the 8 data bits, held for CLK_DIV cycles.
  - Frame becomes 11 bits.
- LA_UART_PARITY_EN undefined: no PARITY state and no parity logic; 8N1 frame.

## Structure
- Package la_uart_pkg holds:
  - The FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - LA bit-index constants: LA_DATA_LSB=0, LA_WR_BIT=8, LA_FLUSH_BIT=9, STAT_BUSY=5, STAT_OVF=6, STAT_FULL=7.
- Sub-module la_uart_fifo: parameterized synchronous FIFO.
  - Ports: push, pop, flush, wdata, rdata, level, full, empty.
  - Same clock and resetb.

## Test plan
- Reset release → uart_tx=1, la_data_out=32'h0, no transitions on uart_tx for 1000 cycles.
- CLK_DIV=4; write 0x41 via one toggle of bit 8 →
  - uart_tx low 2 cycles after the toggle.
  - Data bits 1,0,0,0,0,0,1,0, each 4 cycles, then a stop bit.
  - Frame is 40 cycles; busy clears afterwards.
- CLK_DIV=4; 9 toggles on consecutive cycles (0x00..0x08) →
  - full=1, level=8, overflow=1.
  - 8 contiguous frames of 0x00..0x07; 0x08 is never sent.
- Toggle bit 8 while la_oenb[8]=1 → level stays 0 and uart_tx stays high.
- Flush asserted mid-DATA of 0x55 with 3 bytes queued →
  - uart_tx=1 next cycle, level=0, overflow=0.
  - No further frames after flush deasserts.
- Build with LA_UART_PARITY_EN, CLK_DIV=4, byte 0x07 → parity bit=1, frame 44 cycles; the tbuart-side decoder checks it.
